back_iconch_controller: RTL
===========================

# back_iconch_controller

Sequencing controller for one backend interconnect channel. It arbitrates operand-transfer requests from consumer-side requesters and runs each granted transfer in two phases on the channel. The fetch phase asks the producing EU's channel interface for data at a source address. The deliver phase broadcasts that data to the receiving channel interfaces and waits for acceptance. It sits directly upstream of the per-EU channel interfaces, which decode its channel output.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; 2 to 16.
- MAX_WAIT, 15: fetch-phase timeout in cycles. Only used with the timeout feature; counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester transfer request; level held until done_o or err_o.
- req_addr_i  in  NUM_REQ x type_exec_unit_addr  source address per requester.
- done_o  out  NUM_REQ  one-hot, one-cycle pulse: transfer delivered.
- err_o  out  NUM_REQ  one-hot, one-cycle pulse: fetch timed out (timeout build only; tied 0 otherwise).
- busy_o  out  1  high in any state except IDLE.
- icon_tx_o  out  type_icon_tx_channel_chside  channel drive: req_valid, req_tx_valid, data_valid_tx, data_tx, src_addr.
- icon_rx_i  in  type_icon_rx_channel_chside  OR-reduced return from all attached interfaces: data_rx, data_valid_rx, success.

## Operation
- FSM states: IDLE, FETCH, DELIVER, DONE.
- IDLE:
  - If any req_valid_i is set, grant one requester via round-robin. Register the grant index and req_addr_i, then go to FETCH.
  - The round-robin pointer starts at the index after the last granted requester. After reset it starts at 0.
- FETCH:
  - Drive req_tx_valid=1, src_addr=latched addr, req_valid=0, data_valid_tx=0, data_tx=0.
  - When data_valid_rx=1, latch data_rx into data_reg and go to DELIVER.
- DELIVER:
  - Drive req_valid=1, data_valid_tx=1, data_tx=data_reg, src_addr=latched addr, req_tx_valid=0.
  - Hold until success=1, then go to DONE.
- DONE:
  - done_o[grant]=1 for this single cycle. All channel fields are 0. Go to IDLE.
  - req_valid_i is ignored in DONE; the requester must drop its request in this cycle.
- In IDLE and DONE every icon_tx_o field is 0.
- A requester that drops req_valid_i mid-transfer does not abort the transfer; done_o still pulses.
- If data_valid_rx and success are both high in FETCH, only data_valid_rx is acted on.

## Timing
- Reset: state=IDLE, pointer=0, data_reg=0, timeout counter=0. done_o=0, err_o=0, busy_o=0, and all icon_tx_o fields are 0.
- Reset asserted mid-transfer returns to IDLE next edge with no done_o/err_o pulse.
- Best-case latency is 3 cycles:
  - Request sampled in IDLE at edge 0.
  - FETCH in cycle 1, with same-cycle data_valid_rx.
  - DELIVER in cycle 2, with same-cycle success.
  - done_o in cycle 3.
- Next grant possible in cycle 4.
- Channel outputs are registered-state decodes with no combinational path from icon_rx_i to icon_tx_o.
- data_reg captures on the edge ending the FETCH cycle in which data_valid_rx=1.

## Configuration
- ICONCH_CTRL_TIMEOUT_EN defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without data_valid_rx.
  - When the count reaches MAX_WAIT with no data_valid_rx, the FSM goes to DONE, pulses err_o[grant] instead of done_o, and never enters DELIVER.
  - DELIVER has no timeout.
- Undefined: FETCH waits indefinitely. err_o is constant 0 and no counter is instantiated.

## Structure
- Package pkg_dtypes holds:
  - the FSM state enum type_iconch_ctrl_state (IDLE, FETCH, DELIVER, DONE);
  - the existing channel structs and type_exec_unit_addr;
  - type_exec_unit_data, used for data_reg.
- One sub-module: back_iconch_rr_arbiter, parameterised by NUM_REQ.
  - Inputs: request vector, pointer, advance.
  - Outputs: one-hot grant and binary index.
  - Registered pointer lives inside it.

## Test plan
- Single requester: req_valid_i=4'b0001 with addr euidx=2 and data_valid_rx in first FETCH cycle with data_rx=0xA5. Required: icon_tx_o.data_tx=0xA5 in DELIVER; success same cycle; done_o=4'b0001 in cycle 3.
- All four requesting continuously, instant responses. Required: grants in order 0,1,2,3,0, each done_o pulse 4 cycles apart.
- Delayed producer: data_valid_rx arrives 5 cycles into FETCH, then success 3 cycles into DELIVER. Required: req_tx_valid high for 6 cycles, req_valid high for 4 cycles, then a single done_o.
- Timeout build, MAX_WAIT=15, producer never responds. Required: err_o[grant] pulses once, DELIVER is never entered, and done_o stays 0.
- Reset asserted during DELIVER. Required: next cycle all outputs are 0 and state is IDLE; a fresh request then completes normally with pointer restarting at 0.

Source files
------------

// File: rtl/back_iconch_controller_pkg.sv
// Shared types for the backend interconnect channel controller: FSM state,
// execution-unit address/data and the channel-side tx/rx structs.
package pkg_dtypes;

  localparam int EXEC_UNIT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    DONE    = 2'd3
  } type_iconch_ctrl_state;

  typedef struct packed {
    logic [3:0] euidx;
    logic [3:0] regidx;
  } type_exec_unit_addr;

  typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    logic               req_valid;
    logic               req_tx_valid;
    logic               data_valid_tx;
    type_exec_unit_data data_tx;
    type_exec_unit_addr src_addr;
  } type_icon_tx_channel_chside;

  typedef struct packed {
    type_exec_unit_data data_rx;
    logic               data_valid_rx;
    logic               success;
  } type_icon_rx_channel_chside;

endpackage

// File: rtl/back_iconch_controller_rr_arbiter.sv
// Round-robin arbiter for the interconnect channel controller; the search
// starts at the registered pointer, which moves past the winner on advance.
module back_iconch_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/back_iconch_controller.sv
// Two-phase (fetch, deliver) sequencer for one backend interconnect channel.
// Optional fetch timeout with err_o reporting: define ICONCH_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | channel quiet, arbitrating requesters
// FETCH   | asking producer EU for data at src_addr
// DELIVER | broadcasting data_reg, waiting for success
// DONE    | one-cycle done_o/err_o pulse to the granted requester
module back_iconch_controller
  import pkg_dtypes::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req_valid_i,
  input  type_exec_unit_addr [NUM_REQ-1:0]         req_addr_i,
  output logic [NUM_REQ-1:0]                       done_o,
  output logic [NUM_REQ-1:0]                       err_o,
  output logic                                     busy_o,
  output type_icon_tx_channel_chside               icon_tx_o,
  input  type_icon_rx_channel_chside               icon_rx_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  type_iconch_ctrl_state state;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_advance;
  logic [NUM_REQ-1:0]    grant_q;
  type_exec_unit_addr    src_addr;
  type_exec_unit_data    data_reg;

  assign arb_advance = (state == IDLE) && (|req_valid_i);

  back_iconch_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid_i),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef ICONCH_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      src_addr <= '0;
      data_reg <= '0;
      done_o   <= '0;
`ifdef ICONCH_CTRL_TIMEOUT_EN
      err_o    <= '0;
      wait_cnt <= '0;
`endif
    end else begin
      done_o <= '0;
`ifdef ICONCH_CTRL_TIMEOUT_EN
      err_o  <= '0;
`endif
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q  <= arb_grant;
            src_addr <= req_addr_i[arb_idx];
            state    <= FETCH;
`ifdef ICONCH_CTRL_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        FETCH: begin
          // data_valid_rx takes priority; success is ignored in this phase
          if (icon_rx_i.data_valid_rx) begin
            data_reg <= icon_rx_i.data_rx;
            state    <= DELIVER;
`ifdef ICONCH_CTRL_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            wait_cnt <= wait_cnt + 1'b1;
            err_o    <= grant_q;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        DELIVER: begin
          if (icon_rx_i.success) begin
            done_o <= grant_q;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel drive is a pure decode of registered state: no rx-to-tx path.
  always_comb begin
    icon_tx_o = '0;
    case (state)
      FETCH: begin
        icon_tx_o.req_tx_valid = 1'b1;
        icon_tx_o.src_addr     = src_addr;
      end
      DELIVER: begin
        icon_tx_o.req_valid     = 1'b1;
        icon_tx_o.data_valid_tx = 1'b1;
        icon_tx_o.data_tx       = data_reg;
        icon_tx_o.src_addr      = src_addr;
      end
      default: icon_tx_o = '0;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule
